lcd_bus_arbiter: RTL



---
 rtl/lcd_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: power-up init, then round-robin byte writes.
// Ports: clk/reset, per-client req/lock/rs_in/data_in, grant/ack/ready, LCD pins.
module lcd_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int E_WIDTH  = 12,
  parameter int CMD_WAIT = 50,
  parameter int CLR_WAIT = 2000,
  parameter int PWR_WAIT = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   rs_in,
  input  logic [8*NREQ-1:0] data_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              ready,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [7:0]        LCD_DATA
);

  localparam int M1 = (E_WIDTH > CMD_WAIT) ? E_WIDTH : CMD_WAIT;
  localparam int M2 = (CLR_WAIT > PWR_WAIT) ? CLR_WAIT : PWR_WAIT;
  localparam int MW = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MW + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    PWR, SETUP, EHI, HOLD, WAIT, IDLE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, lim;
  logic [1:0]      idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win, jj;
  logic            found;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            last, clr;

  function automatic logic [7:0] init_byte(
    input logic [1:0] i
  );
    unique case (i)
      2'd0: return 8'h38;
      2'd1: return 8'h0C;
      2'd2: return 8'h06;
      2'd3: return 8'h01;
    endcase
  endfunction

  // Clear/home commands need the long settle time.
  assign clr = !rs_q &&
    (data_q inside {8'h01, 8'h02, 8'h03});

  always_comb begin
    lim = '0;
    unique case (state_q)
      PWR:  lim = CW'(PWR_WAIT - 1);
      EHI:  lim = CW'(E_WIDTH - 1);
      WAIT: lim = clr ? CW'(CLR_WAIT - 1)
                      : CW'(CMD_WAIT - 1);
      default: lim = '0;
    endcase
  end

  assign last = (cnt_q == lim);

  // First requester after the last winner.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    jj    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      jj = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    ready_d = ready_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    unique case (state_q)
      PWR: begin
        if (last) begin
          state_d = SETUP;
          rs_d    = 1'b0;
          data_d  = init_byte(idx_q);
        end
      end
      SETUP: state_d = EHI;
      EHI: begin
        if (last) state_d = HOLD;
      end
      HOLD: state_d = WAIT;
      WAIT: begin
        if (last) begin
          if (!ready_q) begin
            if (idx_q == 2'd3) begin
              state_d = IDLE;
              ready_d = 1'b1;
            end else begin
              idx_d   = idx_q + 2'd1;
              data_d  = init_byte(idx_q + 2'd1);
              state_d = SETUP;
            end
          end else if (lock[ptr_q] && req[ptr_q]) begin
            // Owner keeps the bus, no arbitration.
            state_d = SETUP;
            rs_d    = rs_in[ptr_q];
            data_d  = data_in[{ptr_q, 3'b000} +: 8];
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      IDLE: begin
        if (ready_q && found) begin
          state_d = SETUP;
          ptr_d   = win;
          grant_d = NREQ'(1) << win;
          rs_d    = rs_in[win];
          data_d  = data_in[{win, 3'b000} +: 8];
        end
      end
      default: state_d = PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PWR;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Init bytes run with grant_q = 0, so no ack then.
  assign ack      = grant_q &
    {NREQ{(state_q == WAIT) && last}};
  assign grant    = grant_q;
  assign ready    = ready_q;
  assign LCD_E    = (state_q == EHI);
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;

endmodule
